// File: rtl/jtag_dtm.sv
// jtag_dtm: oversampled JTAG TAP plus RISC-V debug v1.0 DTM issuing DMI requests.
// Define JTAG_DTM_IDCODE_EN to include the IDCODE register (otherwise IR 5'h01 is BYPASS).
module jtag_dtm #(
  parameter logic [31:0] IDCODE    = 32'h1000_0CA1,
  parameter int          ABITS     = 7,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iTck,
  input  logic             iTms,
  input  logic             iTdi,
  output logic             oTdo,
  output logic             oTdoEn,
  output logic             oDmiValid,
  output logic             oDmiWrite,
  output logic [ABITS-1:0] oDmiAddr,
  output logic [31:0]      oDmiWdata,
  input  logic             iDmiReady,
  input  logic [31:0]      iDmiRdata
);
  localparam int DW = ABITS + 34;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR,
    PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR,
    PAU_IR, EX2_IR, UPD_IR
  } tap_e;

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms;
  logic       tdi;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], iTck};
      tms_q <= {tms_q[0], iTms};
      tdi_q <= {tdi_q[0], iTdi};
    end
  end

  assign tck_rise = tck_q[1] & ~tck_q[2];
  assign tck_fall = ~tck_q[1] & tck_q[2];
  assign tms      = tms_q[1];
  assign tdi      = tdi_q[1];

  tap_e state;
  tap_e state_nx;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      state <= TLR;
    else if (tck_rise)
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      TLR:    state_nx = tms ? TLR    : RTI;
      RTI:    state_nx = tms ? SEL_DR : RTI;
      SEL_DR: state_nx = tms ? SEL_IR : CAP_DR;
      CAP_DR: state_nx = tms ? EX1_DR : SH_DR;
      SH_DR:  state_nx = tms ? EX1_DR : SH_DR;
      EX1_DR: state_nx = tms ? UPD_DR : PAU_DR;
      PAU_DR: state_nx = tms ? EX2_DR : PAU_DR;
      EX2_DR: state_nx = tms ? UPD_DR : SH_DR;
      UPD_DR: state_nx = tms ? SEL_DR : RTI;
      SEL_IR: state_nx = tms ? TLR    : CAP_IR;
      CAP_IR: state_nx = tms ? EX1_IR : SH_IR;
      SH_IR:  state_nx = tms ? EX1_IR : SH_IR;
      EX1_IR: state_nx = tms ? UPD_IR : PAU_IR;
      PAU_IR: state_nx = tms ? EX2_IR : PAU_IR;
      EX2_IR: state_nx = tms ? UPD_IR : SH_IR;
      UPD_IR: state_nx = tms ? SEL_DR : RTI;
      default: state_nx = TLR;
    endcase
  end

  // per-state action strobes, each valid only on a detected TCK rise
  logic do_tlr;
  logic do_cap_dr;
  logic do_sh_dr;
  logic do_upd_dr;
  logic do_cap_ir;
  logic do_sh_ir;
  logic do_upd_ir;
  logic in_sh_dr;
  logic in_sh_ir;

  always_comb begin
    do_tlr    = 1'b0;
    do_cap_dr = 1'b0;
    do_sh_dr  = 1'b0;
    do_upd_dr = 1'b0;
    do_cap_ir = 1'b0;
    do_sh_ir  = 1'b0;
    do_upd_ir = 1'b0;
    in_sh_dr  = (state == SH_DR);
    in_sh_ir  = (state == SH_IR);
    unique case (state)
      TLR:    do_tlr    = tck_rise;
      CAP_DR: do_cap_dr = tck_rise;
      SH_DR:  do_sh_dr  = tck_rise;
      UPD_DR: do_upd_dr = tck_rise;
      CAP_IR: do_cap_ir = tck_rise;
      SH_IR:  do_sh_ir  = tck_rise;
      UPD_IR: do_upd_ir = tck_rise;
      default: ;
    endcase
  end

  logic [4:0] ir;
  logic [4:0] ir_sh;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ir    <= 5'h01;
      ir_sh <= '0;
    end else begin
      if (do_tlr)
        ir <= 5'h01;
      else if (do_upd_ir)
        ir <= ir_sh;
      if (do_cap_ir)
        ir_sh <= 5'b00001;
      else if (do_sh_ir)
        ir_sh <= {tdi, ir_sh[4:1]};
    end
  end

  logic sel_idcode;
  logic sel_dtmcs;
  logic sel_dmi;

  always_comb begin
    sel_idcode = 1'b0;
    sel_dtmcs  = (ir == 5'h10);
    sel_dmi    = (ir == 5'h11);
`ifdef JTAG_DTM_IDCODE_EN
    sel_idcode = (ir == 5'h01);
`endif
  end

  logic [1:0]    dmistat;
  logic [31:0]   resp_data;
  logic [31:0]   dtmcs_cap;
  logic [1:0]    cap_op;
  logic [DW-1:0] dr_sh;
  logic [DW-1:0] dr_cap;
  logic [DW-1:0] dr_sh_nx;

  assign dtmcs_cap = {14'b0, 3'b0, IDLE_HINT,
                      dmistat, 6'(ABITS), 4'd1};

  assign cap_op = (dmistat != 2'd0) ? dmistat :
                  oDmiValid         ? 2'd3    : 2'd0;

  always_comb begin
    dr_cap = '0;
    unique case (1'b1)
      sel_idcode: dr_cap[31:0] = IDCODE;
      sel_dtmcs:  dr_cap[31:0] = dtmcs_cap;
      sel_dmi:    dr_cap = {oDmiAddr, resp_data, cap_op};
      default: ;
    endcase
  end

  // TDI enters the MSB of whichever register is selected
  always_comb begin
    dr_sh_nx = dr_sh;
    if (sel_dmi) begin
      dr_sh_nx = {tdi, dr_sh[DW-1:1]};
    end else if (sel_idcode || sel_dtmcs) begin
      dr_sh_nx[30:0] = dr_sh[31:1];
      dr_sh_nx[31]   = tdi;
    end else begin
      dr_sh_nx[0] = tdi;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      dr_sh <= '0;
    else if (do_cap_dr)
      dr_sh <= dr_cap;
    else if (do_sh_dr)
      dr_sh <= dr_sh_nx;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oTdo   <= 1'b0;
      oTdoEn <= 1'b0;
    end else if (tck_fall) begin
      oTdoEn <= in_sh_dr | in_sh_ir;
      if (in_sh_dr)
        oTdo <= dr_sh[0];
      else if (in_sh_ir)
        oTdo <= ir_sh[0];
    end
  end

  logic [1:0] upd_op;
  logic       dmi_done;
  logic       busy;
  logic       dmi_upd;
  logic       dtmcs_upd;
  logic       launch_req;
  logic       cap_busy;

  assign upd_op     = dr_sh[1:0];
  assign dmi_done   = oDmiValid & iDmiReady;
  assign busy       = oDmiValid & ~iDmiReady;
  assign dmi_upd    = do_upd_dr & sel_dmi;
  assign dtmcs_upd  = do_upd_dr & sel_dtmcs;
  assign cap_busy   = do_cap_dr & sel_dmi &
                      (dmistat == 2'd0) & oDmiValid;
  assign launch_req = dmi_upd & (dmistat == 2'd0) &
                      (upd_op == 2'd1 || upd_op == 2'd2);

  // completion is applied before a same-cycle launch
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oDmiValid <= 1'b0;
      oDmiWrite <= 1'b0;
      oDmiAddr  <= '0;
      oDmiWdata <= '0;
      dmistat   <= '0;
      resp_data <= '0;
    end else begin
      if (dmi_done) begin
        oDmiValid <= 1'b0;
        resp_data <= oDmiWrite ? 32'd0 : iDmiRdata;
      end
      if (cap_busy)
        dmistat <= 2'd3;
      if (launch_req) begin
        if (busy) begin
          dmistat <= 2'd3;
        end else begin
          oDmiValid <= 1'b1;
          oDmiWrite <= upd_op[1];
          oDmiAddr  <= dr_sh[DW-1:34];
          oDmiWdata <= dr_sh[33:2];
        end
      end
      if (dtmcs_upd && (dr_sh[16] || dr_sh[17]))
        dmistat <= 2'd0;
      if (dtmcs_upd && dr_sh[17])
        oDmiValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jtag_dtm.sv
// tb_jtag_dtm: randomized JTAG/DMI stimulus against a register-level DTM model.
// Build with JTAG_DTM_IDCODE_EN to expect the IDCODE register after reset.
`timescale 1ns/1ps
module tb_jtag_dtm;
  localparam int ABITS = 7;
  localparam int HALF  = 60;
  localparam logic [2:0] IDLE = 3'd1;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic        iTck = 1'b0;
  logic        iTms = 1'b1;
  logic        iTdi = 1'b0;
  logic        oTdo;
  logic        oTdoEn;
  logic        oDmiValid;
  logic        oDmiWrite;
  logic [6:0]  oDmiAddr;
  logic [31:0] oDmiWdata;
  logic        iDmiReady = 1'b0;
  logic [31:0] iDmiRdata = '0;

  always #5 iClk = ~iClk;

  jtag_dtm dut (
    .iClk(iClk), .iRst_n(iRst_n),
    .iTck(iTck), .iTms(iTms), .iTdi(iTdi),
    .oTdo(oTdo), .oTdoEn(oTdoEn),
    .oDmiValid(oDmiValid), .oDmiWrite(oDmiWrite),
    .oDmiAddr(oDmiAddr), .oDmiWdata(oDmiWdata),
    .iDmiReady(iDmiReady), .iDmiRdata(iDmiRdata)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // register-level model of the DTM
  bit          m_valid = 0;
  bit          m_write = 0;
  logic [6:0]  m_addr  = '0;
  logic [31:0] m_wdata = '0;
  logic [31:0] m_resp  = '0;
  logic [1:0]  m_stat  = '0;

  bit          chk_en = 0;
  bit          resp_en = 0;
  bit          rd_fixed_en = 0;
  int          resp_dly = -1;
  logic [31:0] rd_fixed = '0;
  int          r_dly;
  logic [31:0] r_rd;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (chk_en) begin
      chk("dmi_valid", 64'(oDmiValid), 64'(m_valid));
      if (m_valid) begin
        chk("dmi_write", 64'(oDmiWrite), 64'(m_write));
        chk("dmi_addr", 64'(oDmiAddr), 64'(m_addr));
        if (m_write)
          chk("dmi_wdata", 64'(oDmiWdata), 64'(m_wdata));
      end
    end
  end

  // debug-module side responder
  initial begin
    forever begin
      @(negedge iClk);
      if (resp_en && chk_en && oDmiValid) begin
        r_dly = (resp_dly >= 0) ? resp_dly : int'($urandom_range(0, 5));
        r_rd  = rd_fixed_en ? rd_fixed : $urandom;
        repeat (r_dly) @(negedge iClk);
        iDmiRdata = r_rd;
        iDmiReady = 1'b1;
        @(posedge iClk);
        #1;
        iDmiReady = 1'b0;
        m_resp  = m_write ? 32'd0 : r_rd;
        m_valid = 0;
      end
    end
  end

  task automatic tck(input bit tms, input bit tdi,
                     output bit tdo, output bit en);
    iTms = tms;
    iTdi = tdi;
    #HALF;
    tdo  = oTdo;
    en   = oTdoEn;
    iTck = 1'b1;
    #HALF;
    iTck = 1'b0;
  endtask

  task automatic go_reset;
    bit d, e;
    repeat (5) tck(1, 0, d, e);
    tck(0, 0, d, e);
  endtask

  task automatic scan(input bit ir_sel, input int len,
                      input logic [63:0] din, output logic [63:0] dout);
    bit d, e, o;
    dout = '0;
    tck(1, 0, d, e);
    if (ir_sel) tck(1, 0, d, e);
    tck(0, 0, d, e);
    tck(0, 0, d, e);
    for (int i = 0; i < len; i++) begin
      tck(i == len - 1, din[i], o, e);
      dout[i] = o;
      if (i == 0) chk("tdo_en_shift", 64'(e), 64'd1);
    end
    tck(1, 0, d, e);
    repeat (3) tck(0, 0, d, e);
    @(posedge iClk);
    #1;
    chk("tdo_en_idle", 64'(oTdoEn), 64'd0);
  endtask

  task automatic ir_scan(input logic [4:0] v);
    logic [63:0] o;
    scan(1, 5, 64'(v), o);
    chk("ir_capture", o, 64'h01);
  endtask

  task automatic dmi_scan(input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] op, output logic [63:0] o);
    logic [63:0] exp;
    logic [1:0]  cop;
    chk_en = 0;
    cop = (m_stat != 0) ? m_stat : (m_valid ? 2'd3 : 2'd0);
    if (m_stat == 0 && m_valid) m_stat = 2'd3;
    exp = {23'b0, m_addr, m_resp, cop};
    scan(0, 41, {23'b0, a, d, op}, o);
    chk("dmi_capture", o, exp);
    if ((op == 2'd1 || op == 2'd2) && m_stat == 0) begin
      if (m_valid) begin
        m_stat = 2'd3;
      end else begin
        m_valid = 1;
        m_write = (op == 2'd2);
        m_addr  = a;
        m_wdata = d;
      end
    end
    chk_en = 1;
  endtask

  task automatic dtmcs_scan(input logic [31:0] din, output logic [63:0] o);
    logic [63:0] exp;
    chk_en = 0;
    exp = (64'(IDLE) << 12) | (64'(m_stat) << 10) |
          (64'(ABITS) << 4) | 64'd1;
    scan(0, 32, 64'(din), o);
    chk("dtmcs_capture", o, exp);
    if (din[17]) begin
      m_stat  = 0;
      m_valid = 0;
    end
    if (din[16]) m_stat = 0;
    chk_en = 1;
  endtask

  task automatic wait_idle;
    int t;
    t = 0;
    while (m_valid && t < 300) begin
      @(posedge iClk);
      t++;
    end
    #1;
    chk("dmi_complete", 64'(m_valid), 64'd0);
    m_valid = 0;
  endtask

  task automatic model_reset;
    m_valid = 0;
    m_write = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_resp  = '0;
    m_stat  = '0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] o;
    logic [63:0] din;
    int r;

    repeat (4) @(posedge iClk);
    #1;
    chk("rst_tdo", 64'(oTdo), 64'd0);
    chk("rst_tdoen", 64'(oTdoEn), 64'd0);
    chk("rst_valid", 64'(oDmiValid), 64'd0);
    chk("rst_write", 64'(oDmiWrite), 64'd0);
    chk("rst_addr", 64'(oDmiAddr), 64'd0);
    chk("rst_wdata", 64'(oDmiWdata), 64'd0);
    iRst_n = 1'b1;
    repeat (2) @(posedge iClk);
    chk_en = 1;

    go_reset();
    din = {32'h0, $urandom};
    scan(0, 32, din, o);
`ifdef JTAG_DTM_IDCODE_EN
    chk("idcode", o, 64'h1000_0CA1);
`else
    chk("bypass", o, {32'h0, din[30:0], 1'b0});
`endif

    ir_scan(5'h10);
    dtmcs_scan(32'h0, o);
    chk("dtmcs_lit", o, 64'h0000_1071);

    ir_scan(5'h11);
    resp_en  = 1;
    resp_dly = 3;
    dmi_scan(7'h04, 32'hDEAD_BEEF, 2'd2, o);
    chk("wr_valid_lit", 64'(oDmiValid), 64'd1);
    chk("wr_write_lit", 64'(oDmiWrite), 64'd1);
    chk("wr_addr_lit", 64'(oDmiAddr), 64'h04);
    chk("wr_wdata_lit", 64'(oDmiWdata), 64'hDEAD_BEEF);
    wait_idle();
    @(negedge iClk);
    chk("wr_done_lit", 64'(oDmiValid), 64'd0);

    rd_fixed_en = 1;
    rd_fixed    = 32'h0003_0382;
    dmi_scan(7'h11, 32'h0, 2'd1, o);
    wait_idle();
    dmi_scan(7'h00, 32'h0, 2'd0, o);
    chk("rd_data_lit", {32'h0, o[33:2]}, 64'h0003_0382);
    chk("rd_op_lit", 64'(o[1:0]), 64'd0);
    chk("rd_addr_lit", 64'(o[40:34]), 64'h11);

    resp_en = 0;
    dmi_scan(7'h05, 32'h1234_5678, 2'd2, o);
    dmi_scan(7'h06, 32'h0, 2'd1, o);
    chk("busy_op_lit", 64'(o[1:0]), 64'd3);
    ir_scan(5'h10);
    dtmcs_scan(32'h0, o);
    chk("dtmcs_busy_lit", o, 64'h0000_1C71);
    dtmcs_scan(32'h0001_0000, o);
    dtmcs_scan(32'h0, o);
    chk("dtmcs_clr_lit", o, 64'h0000_1071);

    dtmcs_scan(32'h0002_0000, o);
    chk("abort_lit", 64'(oDmiValid), 64'd0);
    @(negedge iClk);
    iDmiRdata = 32'hFFFF_FFFF;
    iDmiReady = 1'b1;
    @(posedge iClk);
    #1;
    iDmiReady = 1'b0;
    ir_scan(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, o);
    chk("abort_op_lit", 64'(o[1:0]), 64'd0);
    chk("abort_data_lit", {32'h0, o[33:2]}, 64'h0003_0382);

    resp_en     = 1;
    resp_dly    = -1;
    rd_fixed_en = 0;
    for (int k = 0; k < 24; k++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        dmi_scan(7'($urandom), $urandom, 2'($urandom), o);
        wait_idle();
      end else if (r < 9) begin
        ir_scan(5'h10);
        dtmcs_scan($urandom & 32'h0001_0000, o);
        ir_scan(5'h11);
      end else begin
        go_reset();
        ir_scan(5'h11);
      end
    end

    resp_en = 0;
    dmi_scan(7'h33, 32'hAAAA_5555, 2'd2, o);
    chk_en = 0;
    @(posedge iClk);
    #1;
    iRst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge iClk);
    #1;
    chk("midrst_valid", 64'(oDmiValid), 64'd0);
    iRst_n = 1'b1;
    chk_en = 1;
    go_reset();
    ir_scan(5'h11);
    dmi_scan(7'h00, 32'h0, 2'd0, o);
    chk("midrst_cap_lit", o, 64'd0);
    repeat (20) @(posedge iClk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
